spi_arbiter: RTL and testbench

Round-robin scheduler that shares one `spi_master` instance between `NUM_REQ` requesters. Each requester supplies its own transmit byte, SPI mode and clock divider. The arbiter latches the winner's configuration, issues a single-cycle Start, tracks the master's Done handshake and routes the master's SS to that requester's chip select. It returns received data as a one-cycle response, with a timeout error if the master never goes busy.

---
 rtl/spi_arbiter.sv | 145 ++++++++++++++
 tb/tb_spi_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ requesters.
// Latches the winner's config, launches a transfer, tracks Done and returns a one-cycle response.

module spi_arbiter_cs (
  input  logic grant,
  input  logic mss,
  output logic ssn
);
  assign ssn = grant ? mss : 1'b1;
endmodule

module spi_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqTxData,
  input  logic [NUM_REQ*2-1:0]          ReqMode,
  input  logic [NUM_REQ*2-1:0]          ReqClkDiv,
  output logic [NUM_REQ-1:0]            Grant,
  output logic [NUM_REQ-1:0]            RspValid,
  output logic [DATA_WIDTH-1:0]         RspData,
  output logic                          RspErr,
  output logic                          Busy,
  output logic                          MStart,
  output logic [1:0]                    MMode,
  output logic [1:0]                    MClkDiv,
  output logic [DATA_WIDTH-1:0]         MTxData,
  input  logic                          MDone,
  input  logic [DATA_WIDTH-1:0]         MRxData,
  input  logic                          MSS,
  output logic [NUM_REQ-1:0]            SSn
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP, GAP} state_t;

  state_t        state;
  logic [IW-1:0] ptr, idx;
  logic [CW-1:0] tcnt;
  logic [GW-1:0] gcnt;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] tx_arr;
  logic [NUM_REQ-1:0][1:0]            mode_arr, div_arr;

  assign tx_arr   = ReqTxData;
  assign mode_arr = ReqMode;
  assign div_arr  = ReqClkDiv;

  // First requester at or after ptr, wrapping; scanned downward so the nearest slot wins.
  logic [IW-1:0] pick;
  logic          pick_vld;
  int            slot;
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    slot     = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      slot = int'(ptr) + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (Req[slot]) begin
        pick     = IW'(slot);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      tcnt     <= '0;
      gcnt     <= '0;
      Grant    <= '0;
      RspValid <= '0;
      RspData  <= '0;
      RspErr   <= 1'b0;
      Busy     <= 1'b0;
      MStart   <= 1'b0;
      MTxData  <= '0;
      MMode    <= '0;
      MClkDiv  <= '0;
    end else begin
      MStart   <= 1'b0;
      RspValid <= '0;
      case (state)
        IDLE: if (pick_vld) begin
          idx     <= pick;
          Grant   <= NUM_REQ'(1) << pick;
          MTxData <= tx_arr[pick];
          MMode   <= mode_arr[pick];
          MClkDiv <= div_arr[pick];
          MStart  <= 1'b1;
          Busy    <= 1'b1;
          state   <= LAUNCH;
        end
        LAUNCH: begin
          tcnt  <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!MDone) state <= WAIT_DONE;
          else if (tcnt == CW'(BUSY_TIMEOUT-1)) begin
            RspValid <= Grant;
            RspData  <= '0;
            RspErr   <= 1'b1;
            state    <= RESP;
          end else tcnt <= tcnt + 1'b1;
        end
        WAIT_DONE: if (MDone) begin
          RspValid <= Grant;
          RspData  <= MRxData;
          RspErr   <= 1'b0;
          state    <= RESP;
        end
        RESP: begin
          ptr     <= (idx == IW'(NUM_REQ-1)) ? '0 : idx + 1'b1;
          Grant   <= '0;
          RspData <= '0;
          RspErr  <= 1'b0;
          gcnt    <= '0;
          state   <= GAP;
        end
        GAP: begin
          if (gcnt == GW'(GAP_CYCLES-1)) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else gcnt <= gcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Master SS is routed only to the current owner's chip select.
  spi_arbiter_cs u_cs [NUM_REQ-1:0] (.grant(Grant), .mss(MSS), .ssn(SSn));

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: behavioural spi_master stand-in plus a round-robin reference model.
module tb_spi_arbiter;
  localparam int N = 4, DW = 8, GAP = 2, BT = 8;

  logic Clk = 1'b0, Reset = 1'b1;
  logic [N-1:0] Req = '0;
  logic [N-1:0][DW-1:0] tx = '0;
  logic [N-1:0][1:0] md = '0, dv = '0;
  logic [N-1:0] Grant, RspValid, SSn;
  logic [DW-1:0] RspData, MTxData;
  logic [DW-1:0] MRxData = '0;
  logic RspErr, Busy, MStart;
  logic MDone = 1'b1, MSS = 1'b1;
  logic [1:0] MMode, MClkDiv;

  int nvec = 0, nerr = 0, mptr = 0, cyc = 0;
  bit stuck = 1'b0;
  logic [DW-1:0] rx_xor = '0;
  int mcnt = 0;
  bit mact = 1'b0;
  logic [DW-1:0] mrx = '0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  spi_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqTxData(tx), .ReqMode(md), .ReqClkDiv(dv),
    .Grant(Grant), .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr), .Busy(Busy),
    .MStart(MStart), .MMode(MMode), .MClkDiv(MClkDiv), .MTxData(MTxData),
    .MDone(MDone), .MRxData(MRxData), .MSS(MSS), .SSn(SSn));

  // Master stand-in: SS low for 8 SClk periods of 4<<div Clk, Done low meanwhile.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      MDone <= 1'b1; MSS <= 1'b1; mact <= 1'b0; mcnt <= 0;
    end else if (mact) begin
      if (mcnt == 0) begin
        mact <= 1'b0; MDone <= 1'b1; MSS <= 1'b1; MRxData <= mrx;
      end else mcnt <= mcnt - 1;
    end else if (MStart && !stuck) begin
      mact <= 1'b1; MDone <= 1'b0; MSS <= 1'b0;
      mcnt <= 8 * (4 << MClkDiv) - 1;
      mrx <= MTxData ^ rx_xor;
      MRxData <= DW'($urandom);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic tick;
    @(posedge Clk); #1;
  endtask

  task automatic wait_mstart(output bit ok, output int t);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 2000; i++) begin
      if (MStart === 1'b1) begin ok = 1'b1; t = cyc; return; end
      tick();
    end
  endtask

  task automatic wait_rsp(output bit ok, output int t, output bit stable, output int ss_low,
                          output logic [N-1:0] ss_val, output int nstart);
    logic [N-1:0] g0; logic [DW-1:0] d0; logic [1:0] m0, c0;
    g0 = Grant; d0 = MTxData; m0 = MMode; c0 = MClkDiv;
    ok = 1'b0; t = 0; stable = 1'b1; ss_low = 0; ss_val = '1; nstart = 0;
    for (int i = 0; i < 2000; i++) begin
      if (Grant !== g0 || MTxData !== d0 || MMode !== m0 || MClkDiv !== c0) stable = 1'b0;
      if (RspValid !== '0) begin ok = 1'b1; t = cyc; return; end
      if (MStart === 1'b1) nstart++;
      if (SSn !== '1) begin ss_low++; ss_val = SSn; end
      tick();
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Req = '0;
    tick(); tick();
    nvec++; if ({Grant, RspValid, RspErr, Busy, MStart} !== '0) begin nerr++;
      $display("FAIL reset_ctrl: got %b want 0", {Grant, RspValid, RspErr, Busy, MStart}); end
    nvec++; if ({RspData, MTxData, MMode, MClkDiv} !== '0) begin nerr++;
      $display("FAIL reset_data: got %h want 0", {RspData, MTxData, MMode, MClkDiv}); end
    nvec++; if (SSn !== '1) begin nerr++; $display("FAIL reset_ssn: got %b want 1111", SSn); end
    Reset = 1'b0; mptr = 0;
    tick();
  endtask

  task automatic test_single;
    bit ok, st; int ts, tr, sl, ns; logic [N-1:0] sv;
    stuck = 0; rx_xor = '0; tx[0] = 8'hA5; md[0] = 2'd0; dv[0] = 2'd0; Req = 4'b0001;
    wait_mstart(ok, ts);
    nvec++; if (!ok) begin nerr++; $display("FAIL single_start: no MStart"); return; end
    nvec++; if ({Grant, MTxData, MMode, MClkDiv, Busy} !== {4'b0001, 8'hA5, 4'h0, 1'b1}) begin nerr++;
      $display("FAIL single_launch: got %b/%h/%b want 0001/a5/0000", Grant, MTxData, {MMode, MClkDiv}); end
    tick();
    nvec++; if (MStart !== 1'b0) begin nerr++; $display("FAIL single_pulse: MStart %b want 0", MStart); end
    wait_rsp(ok, tr, st, sl, sv, ns);
    nvec++; if (!ok) begin nerr++; $display("FAIL single_rsp: timeout"); return; end
    nvec++; if (ns != 0 || !st) begin nerr++; $display("FAIL single_stable: extra starts %0d stable %b", ns, st); end
    nvec++; if (sv !== 4'b1110) begin nerr++; $display("FAIL single_ssn: got %b want 1110", sv); end
    nvec++; if ({RspValid, RspData, RspErr} !== {4'b0001, 8'hA5, 1'b0}) begin nerr++;
      $display("FAIL single_resp: got %b/%h/%b want 0001/a5/0", RspValid, RspData, RspErr); end
    Req = '0; mptr = 1;
    tick();
    nvec++; if ({Grant, RspValid, Busy} !== {8'h0, 1'b1}) begin nerr++;
      $display("FAIL single_gap: got %b want 000000001", {Grant, RspValid, Busy}); end
    repeat (GAP - 1) tick();
    nvec++; if (Busy !== 1'b1) begin nerr++; $display("FAIL single_gap_end: Busy %b want 1", Busy); end
    tick();
    nvec++; if (Busy !== 1'b0) begin nerr++; $display("FAIL single_idle: Busy %b want 0", Busy); end
  endtask

  task automatic test_contention;
    bit ok, st; int ts, tr, sl, ns, ex; logic [N-1:0] sv; int t_rsp;
    Reset = 1'b1; tick(); Reset = 1'b0; mptr = 0; t_rsp = 0;
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44; md = '0; dv = '0;
    rx_xor = DW'($urandom); Req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_mstart(ok, ts);
      nvec++; if (!ok) begin nerr++; $display("FAIL cont_start: no MStart #%0d", n); Req = '0; return; end
      ex = rr_pick(Req, mptr);
      nvec++; if (Grant !== onehot(ex)) begin nerr++; $display("FAIL cont_grant: got %b want %b", Grant, onehot(ex)); end
      if (n > 0) begin
        nvec++; if (ts - t_rsp != GAP + 2) begin nerr++;
          $display("FAIL cont_gap: rsp-to-start %0d want %0d", ts - t_rsp, GAP + 2); end
      end
      tick();
      wait_rsp(ok, tr, st, sl, sv, ns);
      nvec++; if (!ok) begin nerr++; $display("FAIL cont_rsp: timeout"); Req = '0; return; end
      nvec++; if ({RspValid, RspData, RspErr} !== {onehot(ex), tx[ex] ^ rx_xor, 1'b0}) begin nerr++;
        $display("FAIL cont_resp: got %b/%h/%b want %b/%h/0", RspValid, RspData, RspErr, onehot(ex), tx[ex] ^ rx_xor); end
      mptr = (ex + 1) % N; t_rsp = tr;
      if (n == 4) Req = '0;
    end
    repeat (GAP + 2) tick();
  endtask

  task automatic test_config;
    bit ok, st; int ts, tr, sl, ns, ex; logic [N-1:0] sv;
    md[2] = 2'd3; dv[2] = 2'd3; md[1] = 2'd1; dv[1] = 2'd0;
    tx[1] = DW'($urandom); tx[2] = DW'($urandom); rx_xor = '0; Req = 4'b0110;
    for (int n = 0; n < 2; n++) begin
      wait_mstart(ok, ts);
      nvec++; if (!ok) begin nerr++; $display("FAIL cfg_start: no MStart"); Req = '0; return; end
      ex = rr_pick(Req, mptr);
      nvec++; if ({Grant, MMode, MClkDiv} !== {onehot(ex), md[ex], dv[ex]}) begin nerr++;
        $display("FAIL cfg_route: got %b/%0d/%0d want %b/%0d/%0d", Grant, MMode, MClkDiv, onehot(ex), md[ex], dv[ex]); end
      tick();
      wait_rsp(ok, tr, st, sl, sv, ns);
      nvec++; if (!ok) begin nerr++; $display("FAIL cfg_rsp: timeout"); Req = '0; return; end
      nvec++; if (!st) begin nerr++; $display("FAIL cfg_stable: config changed before response"); end
      nvec++; if (sl != 8 * (4 << dv[ex]) || sv !== ~onehot(ex)) begin nerr++;
        $display("FAIL cfg_ss: low %0d cycles on %b want %0d on %b", sl, sv, 8 * (4 << dv[ex]), ~onehot(ex)); end
      nvec++; if (RspData !== tx[ex]) begin nerr++; $display("FAIL cfg_data: got %h want %h", RspData, tx[ex]); end
      mptr = (ex + 1) % N; Req[ex] = 1'b0;
    end
    repeat (GAP + 2) tick();
  endtask

  task automatic test_withdraw;
    bit ok, st; int ts, tr, sl, ns, bad; logic [N-1:0] sv;
    tx[0] = DW'($urandom); dv[0] = 2'd2; Req = 4'b0001;
    wait_mstart(ok, ts);
    nvec++; if (!ok) begin nerr++; $display("FAIL wd_start: no MStart"); Req = '0; return; end
    repeat (3) tick();
    Req[1] = 1'b1; tick(); Req[1] = 1'b0;
    wait_rsp(ok, tr, st, sl, sv, ns);
    nvec++; if (!ok || RspValid !== 4'b0001) begin nerr++; $display("FAIL wd_rsp: got %b want 0001", RspValid); end
    Req = '0; mptr = 1; bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (Grant[1] === 1'b1 || RspValid[1] === 1'b1 || MStart === 1'b1) bad++;
    end
    nvec++; if (bad != 0) begin nerr++; $display("FAIL wd_served: %0d cycles with req1 activity want 0", bad); end
  endtask

  task automatic test_timeout;
    bit ok, st; int ts, tr, sl, ns, r, ex; logic [N-1:0] sv;
    stuck = 1'b1; r = $urandom_range(0, N - 1); tx[r] = DW'($urandom); dv[r] = 2'd0; Req = onehot(r);
    wait_mstart(ok, ts);
    nvec++; if (!ok) begin nerr++; $display("FAIL to_start: no MStart"); Req = '0; stuck = 0; return; end
    tick();
    wait_rsp(ok, tr, st, sl, sv, ns);
    nvec++; if (!ok || tr - ts != BT + 1) begin nerr++;
      $display("FAIL to_latency: start-to-rsp %0d want %0d", tr - ts, BT + 1); end
    nvec++; if ({RspValid, RspData, RspErr} !== {onehot(r), 8'h00, 1'b1}) begin nerr++;
      $display("FAIL to_resp: got %b/%h/%b want %b/00/1", RspValid, RspData, RspErr, onehot(r)); end
    stuck = 1'b0; mptr = (r + 1) % N;
    tx = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)}; dv = '0; Req = '1;
    wait_mstart(ok, ts);
    ex = rr_pick(Req, mptr);
    nvec++; if (!ok || Grant !== onehot(ex)) begin nerr++;
      $display("FAIL to_ptr: got %b want %b", Grant, onehot(ex)); end
    tick();
    wait_rsp(ok, tr, st, sl, sv, ns);
    Req = '0; mptr = (ex + 1) % N;
    nvec++; if (!ok || RspData !== tx[ex] ^ rx_xor) begin nerr++;
      $display("FAIL to_next: got %h want %h", RspData, tx[ex] ^ rx_xor); end
    repeat (GAP + 2) tick();
  endtask

  task automatic test_reset_mid;
    bit ok, st; int ts, tr, sl, ns; logic [N-1:0] sv;
    tx[0] = DW'($urandom); dv[0] = 2'd3; Req = 4'b0001;
    wait_mstart(ok, ts);
    nvec++; if (!ok) begin nerr++; $display("FAIL rm_start: no MStart"); Req = '0; return; end
    repeat (5) tick();
    nvec++; if (Busy !== 1'b1 || SSn !== 4'b1110) begin nerr++;
      $display("FAIL rm_pre: busy %b ssn %b want 1/1110", Busy, SSn); end
    #2 Reset = 1'b1; #1;
    nvec++; if ({Grant, RspValid, RspErr, Busy, MStart, RspData, MTxData, MMode, MClkDiv} !== '0 || SSn !== '1) begin nerr++;
      $display("FAIL rm_reset: grant %b busy %b mtx %h ssn %b want all idle", Grant, Busy, MTxData, SSn); end
    Req = 4'b0010; tx[1] = DW'($urandom); dv[1] = 2'd1; mptr = 0;
    #1 Reset = 1'b0;
    tick();
    wait_mstart(ok, ts);
    nvec++; if (!ok || Grant !== 4'b0010) begin nerr++; $display("FAIL rm_grant: got %b want 0010", Grant); end
    tick();
    wait_rsp(ok, tr, st, sl, sv, ns);
    nvec++; if (!ok || {RspValid, RspData, RspErr} !== {4'b0010, tx[1] ^ rx_xor, 1'b0}) begin nerr++;
      $display("FAIL rm_resp: got %b/%h/%b want 0010/%h/0", RspValid, RspData, RspErr, tx[1] ^ rx_xor); end
    Req = '0; mptr = 2;
    repeat (GAP + 2) tick();
  endtask

  task automatic test_back_to_back;
    bit ok, st; int t1, t2, tr, sl, ns; logic [N-1:0] sv;
    tx[2] = DW'($urandom); dv[2] = 2'd0; rx_xor = DW'($urandom); Req = 4'b0100;
    wait_mstart(ok, t1);
    tick();
    wait_rsp(ok, tr, st, sl, sv, ns);
    nvec++; if (!ok || RspValid !== 4'b0100) begin nerr++; $display("FAIL b2b_first: got %b want 0100", RspValid); end
    wait_mstart(ok, t2);
    nvec++; if (!ok || t2 - tr != GAP + 2 || Grant !== 4'b0100) begin nerr++;
      $display("FAIL b2b_gap: rsp-to-start %0d grant %b want %0d/0100", t2 - tr, Grant, GAP + 2); end
    tick();
    wait_rsp(ok, tr, st, sl, sv, ns);
    Req = '0; mptr = 3;
    nvec++; if (!ok || RspData !== tx[2] ^ rx_xor) begin nerr++;
      $display("FAIL b2b_second: got %h want %h", RspData, tx[2] ^ rx_xor); end
    repeat (GAP + 2) tick();
  endtask

  task automatic test_random;
    bit ok, st; int ts, tr, sl, ns, ex; logic [N-1:0] sv, nw;
    Req = '0;
    for (int it = 0; it < 40; it++) begin
      nw = (Req == '0) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
      for (int i = 0; i < N; i++) if (nw[i]) begin
        tx[i] = DW'($urandom); md[i] = 2'($urandom); dv[i] = 2'($urandom_range(0, 1));
      end
      Req = Req | nw;
      wait_mstart(ok, ts);
      nvec++; if (!ok) begin nerr++; $display("FAIL rnd_start: no MStart it %0d", it); Req = '0; return; end
      ex = rr_pick(Req, mptr);
      nvec++; if ({Grant, MTxData, MMode, MClkDiv} !== {onehot(ex), tx[ex], md[ex], dv[ex]}) begin nerr++;
        $display("FAIL rnd_grant: got %b/%h/%0d/%0d want %b/%h/%0d/%0d", Grant, MTxData, MMode, MClkDiv,
                 onehot(ex), tx[ex], md[ex], dv[ex]); end
      tick();
      wait_rsp(ok, tr, st, sl, sv, ns);
      nvec++; if (!ok || {RspValid, RspData, RspErr} !== {onehot(ex), tx[ex] ^ rx_xor, 1'b0}) begin nerr++;
        $display("FAIL rnd_resp: got %b/%h/%b want %b/%h/0", RspValid, RspData, RspErr, onehot(ex), tx[ex] ^ rx_xor); end
      mptr = (ex + 1) % N; Req[ex] = 1'b0; rx_xor = DW'($urandom);
      nw = N'($urandom) & ~Req;
      for (int i = 0; i < N; i++) if (nw[i]) begin
        tx[i] = DW'($urandom); md[i] = 2'($urandom); dv[i] = 2'($urandom_range(0, 1));
      end
      Req = Req | nw;
    end
    Req = '0;
    repeat (GAP + 2) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_config();
    test_withdraw();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
